// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-step shift/rotate
// operations (SHL, SHR, ASR, ROL, ROR) under a start/busy/done handshake.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    state_t           r_state, w_state_nx;
    logic [AMT_W-1:0] r_cnt, w_cnt_nx;
    logic [2:0]       r_mode, w_mode_nx;
    logic [WIDTH-1:0] r_q, w_q_nx;
    logic             r_done, w_done_nx;

    // One step of a shift/rotate; serial fills are the live inputs.
    function automatic logic [WIDTH-1:0] step(input logic [2:0] m,
                                              input logic [WIDTH-1:0] v,
                                              input logic fr, input logic fl);
        case (m)
            M_SHL:   step = {v[WIDTH-2:0], fr};
            M_SHR:   step = {fl, v[WIDTH-1:1]};
            M_ROL:   step = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   step = {v[0], v[WIDTH-1:1]};
            M_ASR:   step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: step = v;
        endcase
    endfunction

    // State, counter, latched mode, data and done pulse registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= M_HOLD;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_mode  <= w_mode_nx;
            r_q     <= w_q_nx;
            r_done  <= w_done_nx;
        end
    end

    // Next-state logic: clear dominates, IDLE accepts, RUN steps down the count.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_mode_nx  = r_mode;
        w_q_nx     = r_q;
        w_done_nx  = 1'b0;
        if (clear) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_q_nx     = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        case (mode)
                            M_LOAD: begin
                                w_q_nx    = d;
                                w_done_nx = 1'b1;
                            end
                            M_SHL, M_SHR, M_ROL, M_ROR, M_ASR: begin
                                if (amount == '0) begin
                                    w_done_nx = 1'b1;
                                end else begin
                                    w_mode_nx  = mode;
                                    w_cnt_nx   = amount;
                                    w_state_nx = RUN;
                                end
                            end
                            // HOLD and the reserved code complete immediately.
                            default: w_done_nx = 1'b1;
                        endcase
                    end
                end
                RUN: begin
                    w_q_nx   = step(r_mode, r_q, sin_r, sin_l);
                    w_cnt_nx = r_cnt - AMT_W'(1);
                    if (r_cnt == AMT_W'(1)) begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = (r_state == RUN);
    assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, AMT_W=4).
module tb_univ_shift_reg;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] d;
    logic       sin_r, sin_l, clear;
    logic [7:0] q;
    logic       sout_l, sout_r, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
        .clock (clock),
        .resetn(resetn),
        .start (start),
        .mode  (mode),
        .amount(amount),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .clear (clear),
        .q     (q),
        .sout_l(sout_l),
        .sout_r(sout_r),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        start = 1'b1; mode = 3'b001; d = v;
        tick();
        start = 1'b0;
        chk("load_q", q, v);
        chk("load_done", done, 1);
        chk("load_busy", busy, 0);
    endtask

    initial begin
        int bcnt;
        resetn = 1'b0; start = 1'b0; mode = 3'b000; amount = 4'd0;
        d = 8'h00; sin_r = 1'b0; sin_l = 1'b0; clear = 1'b0;
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clock);
        #2 resetn = 1'b1;
        tick();

        // Parallel load A5, then done clears.
        do_load(8'hA5);
        chk("load_soutl", sout_l, 1);
        chk("load_soutr", sout_r, 1);
        tick();
        chk("load_done_off", done, 0);

        // HOLD held high: done on consecutive cycles, q unchanged; reserved mode too.
        start = 1'b1; mode = 3'b000;
        tick();
        chk("hold1_done", done, 1);
        tick();
        chk("hold2_done", done, 1);
        chk("hold_q", q, 8'hA5);
        mode = 3'b111;
        tick();
        start = 1'b0;
        chk("rsvd_done", done, 1);
        chk("rsvd_q", q, 8'hA5);
        tick();

        // SHL by 3 with sin_r=1; a start pulse mid-run is ignored.
        start = 1'b1; mode = 3'b010; amount = 4'd3; sin_r = 1'b1;
        tick();
        chk("shl_acc_q", q, 8'hA5);
        chk("shl_acc_busy", busy, 1);
        chk("shl_acc_done", done, 0);
        mode = 3'b001; d = 8'h00; amount = 4'd0;  // start still high, must be ignored
        tick();
        start = 1'b0;
        chk("shl_s1", q, 8'h4B);
        chk("shl_s1_busy", busy, 1);
        tick();
        chk("shl_s2", q, 8'h97);
        chk("shl_s2_busy", busy, 1);
        tick();
        chk("shl_s3", q, 8'h2F);
        chk("shl_s3_busy", busy, 0);
        chk("shl_done", done, 1);
        chk("shl_soutl", sout_l, 0);
        tick();
        chk("shl_done_off", done, 0);
        sin_r = 1'b0;

        // ROR by 9 wraps to ROR by 1.
        do_load(8'h81);
        start = 1'b1; mode = 3'b101; amount = 4'd9;
        tick();
        start = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            bcnt++;
            tick();
        end
        chk("ror_busy_cycles", bcnt, 9);
        chk("ror_q", q, 8'hC0);
        chk("ror_done", done, 1);
        tick();

        // ASR by 2 then SHR by 2 with sin_l=0.
        do_load(8'h90);
        start = 1'b1; mode = 3'b110; amount = 4'd2;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("asr_q", q, 8'hE4);
        chk("asr_done", done, 1);
        start = 1'b1; mode = 3'b011; amount = 4'd2; sin_l = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("shr_q", q, 8'h39);
        chk("shr_done", done, 1);
        tick();

        // Clear at the 2nd RUN edge of ROL 5, with a simultaneous LOAD request.
        do_load(8'hFF);
        start = 1'b1; mode = 3'b100; amount = 4'd5;
        tick();
        start = 1'b0;
        tick();
        chk("clr_pre_q", q, 8'hFF);
        clear = 1'b1; start = 1'b1; mode = 3'b001; d = 8'h77;
        tick();
        clear = 1'b0; start = 1'b0;
        chk("clr_q", q, 8'h00);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        tick();
        chk("clr_done_after", done, 0);
        chk("clr_q_after", q, 8'h00);
        do_load(8'h3C);
        tick();

        // Async reset mid-run of ROL 6.
        do_load(8'h5A);
        start = 1'b1; mode = 3'b100; amount = 4'd6;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("arst_pre_q", q, 8'h69);
        chk("arst_pre_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        tick();
        #2 resetn = 1'b1;
        tick();
        chk("arst_idle_done", done, 0);
        start = 1'b1; mode = 3'b010; amount = 4'd0; sin_r = 1'b1;
        tick();
        start = 1'b0;
        chk("amt0_q", q, 8'h00);
        chk("amt0_done", done, 1);
        chk("amt0_busy", busy, 0);
        tick();
        chk("amt0_done_off", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
